// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared types and reset constants for the fifo_ram_ctrl queue.
// Widths that depend on module parameters are derived inside the modules.
package fifo_ram_ctrl_pkg;

  // Encoding of the accepted operations this cycle. The value is {pop_ok, push_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  localparam logic RST_FLAG = 1'b0;

  function automatic fifo_op_e decode_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({pop_ok, push_ok});
  endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM with a synchronous write port and a registered read port.
// A read and a write to the same address in one cycle return the old word.
module fifo_dp_ram #(
  parameter int DATA_SIZE       = 6,
  parameter int MAIN_QUEUE_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       wr_en,
  input  logic [MAIN_QUEUE_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0]       wr_data,
  input  logic                       rd_en,
  input  logic [MAIN_QUEUE_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0]       rd_data
);

  localparam int DEPTH = 1 << MAIN_QUEUE_SIZE;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; only the output register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking assignment here is what gives read-before-write on an address collision.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)   rd_data <= '0;
    else if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO: pointer, occupancy, flag and sticky-error logic around fifo_dp_ram.
// A pop of an empty queue is never satisfied by a same-cycle push (no fall-through).
module fifo_ram_ctrl
  import fifo_ram_ctrl_pkg::*;
#(
  parameter int DATA_SIZE       = 6,
  parameter int MAIN_QUEUE_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_SIZE-1:0]       data_in,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_hi,
  input  logic [MAIN_QUEUE_SIZE:0]   umbral_lo,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int DEPTH = 1 << MAIN_QUEUE_SIZE;
  localparam int CW    = MAIN_QUEUE_SIZE + 1;

  logic [MAIN_QUEUE_SIZE-1:0] r_wr_ptr;
  logic [MAIN_QUEUE_SIZE-1:0] r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_valid;
  logic                       r_err_ovf;
  logic                       r_err_unf;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop_ok;
  logic                       w_push_ok;
  fifo_op_e                   w_op;
  logic [CW-1:0]              w_count_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign w_push_ok = push & (~w_full | w_pop_ok);
  assign w_op      = decode_op(w_push_ok, w_pop_ok);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: w_count_nxt = r_count + 1'b1;
      OP_POP:  w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= RST_FLAG;
      r_err_ovf <= RST_FLAG;
      r_err_unf <= RST_FLAG;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_valid <= w_pop_ok;
      if (push && !w_push_ok) r_err_ovf <= 1'b1;
      if (pop && w_empty)     r_err_unf <= 1'b1;
    end
  end

  fifo_dp_ram #(
    .DATA_SIZE       (DATA_SIZE),
    .MAIN_QUEUE_SIZE (MAIN_QUEUE_SIZE)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (w_push_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_pop_ok),
    .rd_addr (r_rd_ptr),
    .rd_data (data_out)
  );

  // Thresholds are compared live; umbral_hi=0 and umbral_lo>=DEPTH saturate naturally.
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (r_count >= umbral_hi);
  assign almost_empty  = (r_count <= umbral_lo);
  assign count         = r_count;
  assign valid_out     = r_valid;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo_ram_ctrl;

  localparam int DS    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop;
  logic [DS-1:0] data_in;
  logic [AW:0]   umbral_hi, umbral_lo;
  logic [DS-1:0] data_out;
  logic          valid_out, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          err_overflow, err_underflow;

  fifo_ram_ctrl #(.DATA_SIZE(DS), .MAIN_QUEUE_SIZE(AW)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .umbral_hi     (umbral_hi),
    .umbral_lo     (umbral_lo),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_q[$];
  bit          m_ovf, m_unf, m_valid;
  int          m_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".afull"}, 32'(almost_full),  32'(n >= int'(umbral_hi)));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= int'(umbral_lo)));
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".data"},  32'(data_out),  32'(m_data));
    check({tag, ".ovf"},   32'(err_overflow),  32'(m_ovf));
    check({tag, ".unf"},   32'(err_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 0;
    m_unf   = 0;
    m_valid = 0;
    m_data  = 0;
  endtask

  // One clock of traffic: drive away from the edge, update the model, check #1 after the edge.
  task automatic step(input bit p, input bit o, input int d, input string tag);
    bit pop_ok, push_ok;
    @(negedge clk);
    push    = p;
    pop     = o;
    data_in = DS'(d);
    @(posedge clk);
    #1;
    pop_ok  = o && (m_q.size() != 0);
    push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
    if (o && !pop_ok)  m_unf = 1;
    if (p && !push_ok) m_ovf = 1;
    if (pop_ok) begin
      m_data  = m_q.pop_front();
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (push_ok) m_q.push_back(d & ((1 << DS) - 1));
    push = 0;
    pop  = 0;
    check_all(tag);
  endtask

  // Assert reset between edges and check that state clears without waiting for a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_L   = 1'b0;
    push      = 0;
    pop       = 0;
    data_in   = '0;
    umbral_hi = 4'd6;
    umbral_lo = 4'd2;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_L = 1'b1;

    // 1: fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) step(1, 0, i, "fill");

    // 2: overflow from full, then drain in order
    step(1, 0, 'h3F, "ovf");
    for (int i = 0; i < 8; i++) step(0, 1, 0, "drain1");

    // 3: push+pop on empty: no fall-through, underflow flagged
    step(1, 1, 'h15, "empty_pp");
    step(0, 1, 0, "empty_pp_pop");
    check("data_15", 32'(data_out), 32'h15);

    // 4: simultaneous push/pop while full, then drain across the wrap
    for (int i = 1; i <= 8; i++) step(1, 0, i, "refill");
    for (int i = 0; i < 4; i++) step(1, 1, 'h20 + i, "full_pp");
    for (int i = 0; i < 8; i++) step(0, 1, 0, "drain2");

    // 5: almost_empty around the threshold, then a live threshold change
    step(1, 0, 'h11, "ae_up");
    step(1, 0, 'h12, "ae_up");
    for (int i = 0; i < 20; i++) step(i % 2 == 0, i % 2 == 1, 'h30 + i, "ae_toggle");
    @(negedge clk);
    umbral_lo = 4'd0;
    #1;
    check("ae_live_lo0", 32'(almost_empty), 32'(m_q.size() == 0));
    @(negedge clk);
    umbral_lo = 4'd2;
    #1;
    check("ae_live_lo2", 32'(almost_empty), 32'(m_q.size() <= 2));

    // 6: async reset with count=5, then a clean round trip
    while (m_q.size() < 5) step(1, 0, 'h05, "pre_rst");
    while (m_q.size() > 5) step(0, 1, 0, "pre_rst");
    check("pre_rst_count", 32'(count), 32'd5);
    async_reset("async_rst");
    step(1, 0, 'h2A, "post_rst_push");
    step(0, 1, 0, "post_rst_pop");
    check("post_rst_data", 32'(data_out), 32'h2A);

    // Random traffic with occasional live threshold changes
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      if ($urandom_range(0, 15) == 0) begin
        umbral_hi = 4'($urandom_range(0, 15));
        umbral_lo = 4'($urandom_range(0, 15));
      end
      if (i == 300) async_reset("rand_rst");
      step($urandom_range(0, 3) < 1 + bias, $urandom_range(0, 3) < 3 - bias,
           int'($urandom_range(0, 63)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
